// File: rtl/sorted_array_reader_if.sv
// Bus bundle for sorted_array_reader: start/status, memory read port and output stream.
// The reverse input exists only when SORTED_ARRAY_READER_REVERSE_EN is defined.
interface sorted_array_reader_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 3
);
  logic              start;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_data;
  logic [WIDTH-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
`ifdef SORTED_ARRAY_READER_REVERSE_EN
  logic              reverse;

  modport master (
    input  start, reverse, mem_data, out_ready,
    output mem_rd, mem_addr, out_data, out_valid, busy, done
  );
  modport slave (
    output start, reverse, mem_data, out_ready,
    input  mem_rd, mem_addr, out_data, out_valid, busy, done
  );
`else
  modport master (
    input  start, mem_data, out_ready,
    output mem_rd, mem_addr, out_data, out_valid, busy, done
  );
  modport slave (
    output start, mem_data, out_ready,
    input  mem_rd, mem_addr, out_data, out_valid, busy, done
  );
`endif
endinterface

// File: rtl/sorted_array_reader.sv
// Streams DEPTH words out of the sort memory, one READ/WAIT/PRESENT pass per word, then pulses done.
// Optional descending walk enabled by defining SORTED_ARRAY_READER_REVERSE_EN.
module sorted_array_reader #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input logic                    i_clk,
  input logic                    i_rst,
  sorted_array_reader_if.master  bus
);

  localparam logic [ADDR_W-1:0] LP_FIRST = '0;
  localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_PRESENT,
    S_FINISH
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [WIDTH-1:0]  r_out_data;
  logic              r_mem_rd;
  logic              r_out_valid;
  logic              r_busy;
  logic              r_done;
  logic              r_rev;
  logic              w_load;
  logic              w_step;
  logic              w_last;
  logic              w_start_rev;

`ifdef SORTED_ARRAY_READER_REVERSE_EN
  assign w_start_rev = bus.reverse;
`else
  assign w_start_rev = 1'b0;
`endif

  assign w_last = r_rev ? (r_addr == LP_FIRST) : (r_addr == LP_LAST);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and counter control
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next = S_READ;
          w_load = 1'b1;
        end
      end
      S_READ:  w_next = S_WAIT;
      S_WAIT:  w_next = S_PRESENT;
      S_PRESENT: begin
        if (bus.out_ready) begin
          if (w_last) begin
            w_next = S_FINISH;
          end else begin
            w_next = S_READ;
            w_step = 1'b1;
          end
        end
      end
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Outputs are registered copies of the next-state decode, so nothing combinational reaches the bus
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr      <= '0;
      r_out_data  <= '0;
      r_mem_rd    <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rev       <= 1'b0;
    end else begin
      r_mem_rd    <= (w_next == S_READ);
      r_out_valid <= (w_next == S_PRESENT);
      r_busy      <= (w_next != S_IDLE);
      r_done      <= (w_next == S_FINISH);
      if (w_load) begin
        r_rev  <= w_start_rev;
        r_addr <= w_start_rev ? LP_LAST : LP_FIRST;
      end else if (w_step) begin
        r_addr <= r_rev ? (r_addr - ADDR_W'(1)) : (r_addr + ADDR_W'(1));
      end
      if (r_state == S_WAIT) begin
        r_out_data <= bus.mem_data;
      end
    end
  end

  assign bus.mem_rd    = r_mem_rd;
  assign bus.mem_addr  = r_addr;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule
